// File: rtl/reg_file_mp.sv
// Multi-read-port, single-write-port register file with hardwired zero entry,
// optional write-to-read bypass and a post-reset hardware clear sweep.
module reg_file_mp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_req,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic                   init_done,
  output logic                   busy
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int unsigned   DEPTH_U  = DEPTH;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic [XLEN-1:0] mem [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic            wr_ok;

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < DEPTH_U;
  endfunction

  // A write is live only in READY, not pre-empted by a clear request, in range
  // and not aimed at the hardwired zero entry; bypass uses the same qualifier.
  assign wr_ok = (state_q == READY) && wr_en && !clr_req && in_range(wr_addr) &&
                 !(ZERO_REG && (wr_addr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      init_done <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      init_done <= (state_d == READY);
      busy      <= (state_d != READY);
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    unique case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        mem_wdata = '0;
        if (clr_idx_q == LAST_IDX) begin
          state_d   = READY;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + AW'(1);
        end
      end
      READY: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end else begin
          mem_we = wr_ok;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_idx_d = '0;
      end
    endcase
  end

  // Storage deliberately has no reset; the clear sweep initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      if (init_done && !(ZERO_REG && (rd_addr[k*AW +: AW] == '0)) &&
          in_range(rd_addr[k*AW +: AW])) begin
        if (BYPASS && wr_ok && (wr_addr == rd_addr[k*AW +: AW]))
          rd_data[k*XLEN +: XLEN] = wr_data;
        else
          rd_data[k*XLEN +: XLEN] = mem[rd_addr[k*AW +: AW]];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (32x2 zero-reg+bypass, 24x4 plain) on a
// shared write bus, checked against an array-based behavioural model.
module tb_reg_file_mp;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clr_req = 1'b0;
  logic         wr_en = 1'b0;
  logic [4:0]   wr_addr = '0;
  logic [31:0]  wr_data = '0;
  logic [9:0]   rd_a = '0;
  logic [19:0]  rd_b = '0;
  logic [63:0]  rdata_a;
  logic [127:0] rdata_b;
  logic         done_a, busy_a, done_b, busy_b;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_a (
    .clk(clk), .rst(rst), .clr_req(clr_req), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_a), .rd_data(rdata_a), .init_done(done_a), .busy(busy_a)
  );

  reg_file_mp #(.XLEN(32), .DEPTH(24), .NUM_RD(4), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_b (
    .clk(clk), .rst(rst), .clr_req(clr_req), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_b), .rd_data(rdata_b), .init_done(done_b), .busy(busy_b)
  );

  // Behavioural model: index 0 = instance a, 1 = instance b.
  logic [31:0] mm [2][32];
  bit          m_ready [2] = '{1'b0, 1'b0};
  int          m_left  [2] = '{32, 24};

  function automatic int dep(input int d);
    return (d == 0) ? 32 : 24;
  endfunction

  function automatic bit zr(input int d);
    return d == 0;
  endfunction

  function automatic bit byp(input int d);
    return d == 0;
  endfunction

  function automatic bit wr_ok(input int d);
    return (wr_en === 1'b1) && (clr_req === 1'b0) && (int'(wr_addr) < dep(d)) &&
           !(zr(d) && wr_addr == 5'd0);
  endfunction

  function automatic logic [31:0] exp_rd(input int d, input logic [4:0] a);
    if (!m_ready[d] || (zr(d) && a == 5'd0) || int'(a) >= dep(d)) return '0;
    if (byp(d) && wr_ok(d) && wr_addr == a) return wr_data;
    return mm[d][a];
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_ready[d] = 1'b0;
        m_left[d]  = dep(d);
      end else if (!m_ready[d]) begin
        m_left[d]--;
        if (m_left[d] == 0) begin
          m_ready[d] = 1'b1;
          for (int i = 0; i < 32; i++) mm[d][i] = '0;
        end
      end else if (clr_req) begin
        m_ready[d] = 1'b0;
        m_left[d]  = dep(d);
      end else if (wr_ok(d)) begin
        mm[d][wr_addr] = wr_data;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    int rise_a, rise_b;
    idle();
    cyc(); cyc();
    rd_a = 10'($urandom); rd_b = 20'($urandom);
    #1;
    total++;
    if ({done_a, busy_a, done_b, busy_b} !== 4'b0101) begin
      bad++; $display("FAIL reset_status got=%b exp=0101", {done_a, busy_a, done_b, busy_b});
    end
    total++;
    if (rdata_a !== '0 || rdata_b !== '0) begin
      bad++; $display("FAIL reset_rdata got_a=%h got_b=%h exp=0", rdata_a, rdata_b);
    end
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        for (int a = 0; a < 32; a++) wr(5'(a), 32'hFFFF_FFFF);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
      end else begin
        rst = 1'b0;
      end
      rise_a = 0; rise_b = 0;
      for (int i = 1; i <= 34; i++) begin
        cyc();
        if (done_a === 1'b1 && rise_a == 0) rise_a = i;
        if (done_b === 1'b1 && rise_b == 0) rise_b = i;
        total++;
        if ({done_a, busy_a, done_b, busy_b} !==
            {m_ready[0], !m_ready[0], m_ready[1], !m_ready[1]}) begin
          bad++; $display("FAIL sweep_status pass=%0d cyc=%0d got=%b exp=%b", pass, i,
            {done_a, busy_a, done_b, busy_b}, {m_ready[0], !m_ready[0], m_ready[1], !m_ready[1]});
        end
      end
      total++;
      if (rise_a != 32 || rise_b != 24) begin
        bad++; $display("FAIL sweep_len pass=%0d got_a=%0d got_b=%0d exp=32/24", pass, rise_a, rise_b);
      end
    end
    for (int a = 0; a < 32; a++) begin
      rd_a = {2{5'(a)}}; rd_b = {4{5'(a)}};
      #1;
      total++;
      if (rdata_a !== '0 || rdata_b !== '0) begin
        bad++; $display("FAIL swept_zero addr=%0d got_a=%h got_b=%h exp=0", a, rdata_a, rdata_b);
      end
    end
  endtask

  task automatic test_write_zero();
    logic [31:0] ea [2];
    logic [31:0] eb [4];
    wr(5'd5, 32'h6); wr(5'd6, 32'h10); wr(5'd0, 32'hDEAD);
    rd_a = {5'd6, 5'd5};
    rd_b = {5'd20, 5'd0, 5'd6, 5'd5};
    ea[0] = 32'h6; ea[1] = 32'h10;
    eb[0] = 32'h6; eb[1] = 32'h10; eb[2] = 32'hDEAD; eb[3] = 32'h0;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (rdata_a[k*32 +: 32] !== ea[k]) begin
        bad++; $display("FAIL wr_rd_a port=%0d got=%h exp=%h", k, rdata_a[k*32 +: 32], ea[k]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (rdata_b[k*32 +: 32] !== eb[k]) begin
        bad++; $display("FAIL wr_rd_b port=%0d got=%h exp=%h", k, rdata_b[k*32 +: 32], eb[k]);
      end
    end
    rd_a = {5'd0, 5'd0};
    #1;
    total++;
    if (rdata_a !== '0) begin
      bad++; $display("FAIL zero_reg got=%h exp=0", rdata_a);
    end
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5;
    rd_a = {2{5'd7}}; rd_b = {4{5'd7}};
    #1;
    total++;
    if (rdata_a !== {2{32'hA5A5_A5A5}}) begin
      bad++; $display("FAIL bypass_a got=%h exp=%h", rdata_a, {2{32'hA5A5_A5A5}});
    end
    total++;
    if (rdata_b !== '0) begin
      bad++; $display("FAIL nobypass_b got=%h exp=0", rdata_b);
    end
    cyc();
    wr_en = 1'b0;
    #1;
    total++;
    if (rdata_b !== {4{32'hA5A5_A5A5}} || rdata_a !== {2{32'hA5A5_A5A5}}) begin
      bad++; $display("FAIL bypass_after got_a=%h got_b=%h exp=a5a5a5a5", rdata_a, rdata_b);
    end
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678;
    rd_a = {2{5'd0}}; rd_b = {4{5'd0}};
    #1;
    total++;
    if (rdata_a !== '0 || rdata_b !== {4{32'h0000_DEAD}}) begin
      bad++; $display("FAIL bypass_x0 got_a=%h got_b=%h exp_a=0 exp_b=dead", rdata_a, rdata_b);
    end
    cyc();
    wr_en = 1'b0;
    #1;
    total++;
    if (rdata_a !== '0 || rdata_b !== {4{32'h1234_5678}}) begin
      bad++; $display("FAIL write_x0 got_a=%h got_b=%h exp_a=0 exp_b=12345678", rdata_a, rdata_b);
    end
  endtask

  task automatic test_out_of_range();
    wr(5'd30, 32'h1234); wr(5'd24, 32'hBEEF); wr(5'd23, 32'h2323);
    rd_a = {5'd24, 5'd30};
    rd_b = {5'd23, 5'd24, 5'd30, 5'd31};
    #1;
    total++;
    if (rdata_a !== {32'hBEEF, 32'h1234}) begin
      bad++; $display("FAIL oor_a got=%h exp=%h", rdata_a, {32'hBEEF, 32'h1234});
    end
    total++;
    if (rdata_b !== {32'h2323, 32'h0, 32'h0, 32'h0}) begin
      bad++; $display("FAIL oor_b got=%h exp=%h", rdata_b, {32'h2323, 96'h0});
    end
    for (int a = 0; a < 24; a++) begin
      rd_b = {4{5'(a)}};
      #1;
      total++;
      if (rdata_b !== {4{exp_rd(1, 5'(a))}}) begin
        bad++; $display("FAIL oor_keep addr=%0d got=%h exp=%h", a, rdata_b[31:0], exp_rd(1, 5'(a)));
      end
    end
  endtask

  task automatic test_clr_req();
    int rise_a, rise_b;
    wr(5'd9, 32'h55);
    clr_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h77;
    rd_a = {2{5'd9}}; rd_b = {4{5'd9}};
    #1;
    total++;
    if (rdata_a !== {2{32'h55}} || rdata_b !== {4{32'h55}}) begin
      bad++; $display("FAIL clr_same_cycle got_a=%h got_b=%h exp=55", rdata_a, rdata_b);
    end
    cyc();
    idle();
    total++;
    if ({done_a, busy_a, done_b, busy_b} !== 4'b0101) begin
      bad++; $display("FAIL clr_busy got=%b exp=0101", {done_a, busy_a, done_b, busy_b});
    end
    rise_a = 0; rise_b = 0;
    for (int i = 1; i <= 34; i++) begin
      clr_req = (i == 5);
      cyc();
      clr_req = 1'b0;
      if (done_a === 1'b1 && rise_a == 0) rise_a = i;
      if (done_b === 1'b1 && rise_b == 0) rise_b = i;
    end
    total++;
    if (rise_a != 32 || rise_b != 24) begin
      bad++; $display("FAIL clr_len got_a=%0d got_b=%0d exp=32/24", rise_a, rise_b);
    end
    #1;
    total++;
    if (rdata_a !== '0 || rdata_b !== '0) begin
      bad++; $display("FAIL clr_x9 got_a=%h got_b=%h exp=0", rdata_a, rdata_b);
    end
  endtask

  task automatic test_rst_mid();
    int rise_a, rise_b;
    rst = 1'b1;
    #1;
    total++;
    if ({done_a, busy_a, done_b, busy_b} !== 4'b0101) begin
      bad++; $display("FAIL async_rst got=%b exp=0101", {done_a, busy_a, done_b, busy_b});
    end
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 34; i++) cyc();
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    for (int i = 1; i < 10; i++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rise_a = 0; rise_b = 0;
    for (int i = 1; i <= 34; i++) begin
      cyc();
      if (done_a === 1'b1 && rise_a == 0) rise_a = i;
      if (done_b === 1'b1 && rise_b == 0) rise_b = i;
    end
    total++;
    if (rise_a != 32 || rise_b != 24) begin
      bad++; $display("FAIL rst_mid_len got_a=%0d got_b=%0d exp=32/24", rise_a, rise_b);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      clr_req = ($urandom_range(0, 59) == 0);
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = $urandom;
      rd_a    = 10'($urandom);
      rd_b    = 20'($urandom);
      if ($urandom_range(0, 2) == 0) rd_a[4:0] = wr_addr;
      if ($urandom_range(0, 2) == 0) rd_b[9:5] = wr_addr;
      #1;
      total++;
      if ({done_a, busy_a, done_b, busy_b} !==
          {m_ready[0], !m_ready[0], m_ready[1], !m_ready[1]}) begin
        bad++; $display("FAIL rand_status n=%0d got=%b exp=%b", n,
          {done_a, busy_a, done_b, busy_b}, {m_ready[0], !m_ready[0], m_ready[1], !m_ready[1]});
      end
      for (int k = 0; k < 2; k++) begin
        total++;
        if (rdata_a[k*32 +: 32] !== exp_rd(0, rd_a[k*5 +: 5])) begin
          bad++; $display("FAIL rand_a n=%0d port=%0d addr=%0d got=%h exp=%h", n, k,
            rd_a[k*5 +: 5], rdata_a[k*32 +: 32], exp_rd(0, rd_a[k*5 +: 5]));
        end
      end
      for (int k = 0; k < 4; k++) begin
        total++;
        if (rdata_b[k*32 +: 32] !== exp_rd(1, rd_b[k*5 +: 5])) begin
          bad++; $display("FAIL rand_b n=%0d port=%0d addr=%0d got=%h exp=%h", n, k,
            rd_b[k*5 +: 5], rdata_b[k*32 +: 32], exp_rd(1, rd_b[k*5 +: 5]));
        end
      end
      cyc();
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_zero();
    test_bypass();
    test_out_of_range();
    test_clr_req();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
